// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, requests words from instruction memory, presents
// each fetched word to the decoder with a valid/ready handshake, selects the
// next PC from the decoder's pc_sel, counts retired instructions, and traps
// (sticky) when a control transfer would land on a misaligned address.
module instr_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  // instruction memory request/ack
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  // decoder side
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] pc_target,
  input  logic [XLEN-1:0] alu_result,
  // status
  output logic            fetch_fault,
  output logic [31:0]     retired
);

  // Word presented to the decoder out of reset: addi x0, x0, 0.
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_BR   = 2'b01;
  localparam logic [1:0] SEL_JALR = 2'b10;
  localparam logic [1:0] SEL_SAME = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_TRAP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   instr_pc_q, instr_pc_d;
  logic [31:0]       retired_q, retired_d;

  logic              fetch_done;
  logic              consume;
  logic [XLEN-1:0]   next_pc;
  logic              next_misaligned;

  // Next-PC mux. jalr targets have bit 0 cleared before use; pc+4 wraps
  // naturally at the top of the address space.
  function automatic logic [XLEN-1:0] calc_next_pc(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] pc,
    input logic [XLEN-1:0] target,
    input logic [XLEN-1:0] alu
  );
    logic [XLEN-1:0] npc;
    case (sel)
      SEL_SEQ:  npc = pc + XLEN'(4);
      SEL_BR:   npc = target;
      SEL_JALR: npc = alu & ~XLEN'(1);
      SEL_SAME: npc = pc;
      default:  npc = pc;
    endcase
    return npc;
  endfunction

  // Instructions are 32-bit aligned; any low-order bit set is a fault.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  assign fetch_done      = (state_q == S_FETCH) && imem_ack;
  assign consume         = (state_q == S_HOLD) && instr_ready;
  assign next_pc         = calc_next_pc(pc_sel, pc_q, pc_target, alu_result);
  assign next_misaligned = is_misaligned(next_pc);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: acks only count in S_FETCH, ready only in S_HOLD;
  // S_TRAP is left only by reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (imem_ack) state_d = S_HOLD;
      S_HOLD:  if (instr_ready) state_d = next_misaligned ? S_TRAP : S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake/status outputs decode from state only, no input paths.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fetch_fault = 1'b0;
    case (state_q)
      S_FETCH: imem_req    = 1'b1;
      S_HOLD:  instr_valid = 1'b1;
      S_TRAP:  fetch_fault = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: capture on ack, advance PC and retire on consume.
  // A trapping consume still retires but leaves the PC on the faulting
  // instruction.
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    retired_d  = retired_q;
    if (fetch_done) begin
      instr_d    = imem_rdata;
      instr_pc_d = pc_q;
    end
    if (consume) begin
      retired_d = retired_q + 32'd1;
      if (!next_misaligned) begin
        pc_d = next_pc;
      end
    end
  end

  // Datapath registers; reset restores the architectural start state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      instr_q    <= NOP;
      instr_pc_q <= RESET_PC;
      retired_q  <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      retired_q  <= retired_d;
    end
  end

  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign instr_pc  = instr_pc_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: two instances share stimulus, one with the
// default reset PC and one starting just below the address-space wrap.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_ready;
  logic [1:0]  pc_sel;
  logic [31:0] pc_target;
  logic [31:0] alu_result;

  logic        a_req, a_valid, a_fault;
  logic [31:0] a_addr, a_instr, a_ipc, a_ret;
  logic        b_req, b_valid, b_fault;
  logic [31:0] b_addr, b_instr, b_ipc, b_ret;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(a_req), .imem_addr(a_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(a_valid), .instr(a_instr), .instr_pc(a_ipc), .instr_ready(instr_ready),
    .pc_sel(pc_sel), .pc_target(pc_target), .alu_result(alu_result),
    .fetch_fault(a_fault), .retired(a_ret)
  );

  instr_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_hi (
    .clk(clk), .rst(rst),
    .imem_req(b_req), .imem_addr(b_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(b_valid), .instr(b_instr), .instr_pc(b_ipc), .instr_ready(instr_ready),
    .pc_sel(pc_sel), .pc_target(pc_target), .alu_result(alu_result),
    .fetch_fault(b_fault), .retired(b_ret)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    pc_sel      = 2'b00;
    pc_target   = 32'h0;
    alu_result  = 32'h0;
    #1;

    // Reset state
    do_reset();
    chk("rst_req",   {31'b0, a_req},   32'd0);
    chk("rst_valid", {31'b0, a_valid}, 32'd0);
    chk("rst_fault", {31'b0, a_fault}, 32'd0);
    chk("rst_instr", a_instr, 32'h0000_0013);
    chk("rst_ipc",   a_ipc,   32'h0);
    chk("rst_ret",   a_ret,   32'h0);
    chk("rst_addr",  a_addr,  32'h0);

    // 1: zero-wait memory, sequential flow
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093; instr_ready = 1'b1; pc_sel = 2'b00;
    tick();
    chk("t1_req0",  {31'b0, a_req}, 32'd1);
    chk("t1_addr0", a_addr, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t1_valid", {31'b0, a_valid}, 32'd1);
      chk("t1_instr", a_instr, 32'h0050_0093);
      chk("t1_ipc",   a_ipc, 32'(4 * (k - 1)));
      tick();
      chk("t1_req",   {31'b0, a_req}, 32'd1);
      chk("t1_addr",  a_addr, 32'(4 * k));
      chk("t1_ret",   a_ret, 32'(k));
    end

    // 2: delayed ack, ready ignored while not valid, instr held while stalled
    do_reset();
    imem_ack = 1'b1; instr_ready = 1'b1;
    tick(); tick(); tick();
    chk("t2_addr4", a_addr, 32'h4);
    imem_ack = 1'b0; imem_rdata = 32'h00A0_0113;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_req_wait",  {31'b0, a_req},   32'd1);
      chk("t2_addr_wait", a_addr,           32'h4);
      chk("t2_nvalid",    {31'b0, a_valid}, 32'd0);
      chk("t2_ret_wait",  a_ret,            32'd1);
    end
    imem_ack = 1'b1; instr_ready = 1'b0;
    tick();
    chk("t2_valid", {31'b0, a_valid}, 32'd1);
    imem_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t2_hold_instr", a_instr, 32'h00A0_0113);
      chk("t2_hold_ipc",   a_ipc,   32'h4);
      chk("t2_hold_valid", {31'b0, a_valid}, 32'd1);
    end
    instr_ready = 1'b1; imem_rdata = 32'h0050_0093;
    tick();
    chk("t2_addr8", a_addr, 32'h8);
    chk("t2_ret2",  a_ret,  32'd2);

    // 3: branch, jalr (bit0 cleared), re-fetch
    tick();
    chk("t3_ipc8", a_ipc, 32'h8);
    pc_sel = 2'b01; pc_target = 32'h40;
    tick();
    chk("t3_br",  a_addr, 32'h40);
    pc_sel = 2'b10; alu_result = 32'h81;
    tick(); tick();
    chk("t3_jalr", a_addr, 32'h80);
    pc_sel = 2'b11;
    tick(); tick();
    chk("t3_same", a_addr, 32'h80);
    chk("t3_req",  {31'b0, a_req}, 32'd1);
    chk("t3_ret",  a_ret, 32'd5);

    // 4: misaligned branch target traps, sticky until reset
    pc_sel = 2'b01; pc_target = 32'h42;
    tick(); tick();
    chk("t4_fault", {31'b0, a_fault}, 32'd1);
    chk("t4_req",   {31'b0, a_req},   32'd0);
    chk("t4_valid", {31'b0, a_valid}, 32'd0);
    chk("t4_ret",   a_ret,  32'd6);
    chk("t4_pc",    a_addr, 32'h80);
    tick(); tick();
    chk("t4_sticky",  {31'b0, a_fault}, 32'd1);
    chk("t4_ret_hold", a_ret, 32'd6);
    do_reset();
    chk("t4_clr", {31'b0, a_fault}, 32'd0);
    tick();
    chk("t4_addr_rst", a_addr, 32'h0);
    chk("t4_req_rst",  {31'b0, a_req}, 32'd1);

    // 5: reset overrides pending ack and pending consume
    do_reset();
    pc_sel = 2'b00; imem_ack = 1'b1; instr_ready = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("t5a_req",   {31'b0, a_req},   32'd0);
    chk("t5a_valid", {31'b0, a_valid}, 32'd0);
    chk("t5a_instr", a_instr, 32'h13);
    rst = 1'b0;
    tick(); tick();
    chk("t5b_valid", {31'b0, a_valid}, 32'd1);
    rst = 1'b1;
    tick();
    chk("t5b_ret",   a_ret,   32'd0);
    chk("t5b_instr", a_instr, 32'h13);
    chk("t5b_req",   {31'b0, a_req}, 32'd0);
    chk("t5b_addr",  a_addr,  32'h0);
    chk("t5b_ipc",   a_ipc,   32'h0);

    // 6: PC wrap at top of address space, retired counter wrap
    do_reset();
    chk("t6_rst_addr", b_addr, 32'hFFFF_FFFC);
    tick();
    chk("t6_addr_hi", b_addr, 32'hFFFF_FFFC);
    chk("t6_req_hi",  {31'b0, b_req}, 32'd1);
    tick();
    chk("t6_ipc_hi",   b_ipc, 32'hFFFF_FFFC);
    chk("t6_instr_hi", b_instr, 32'h0050_0093);
    chk("t6_valid_hi", {31'b0, b_valid}, 32'd1);
    tick();
    chk("t6_wrap_addr", b_addr, 32'h0);
    chk("t6_ret_b",     b_ret,  32'd1);
    chk("t6_fault_b",   {31'b0, b_fault}, 32'd0);
    force dut.retired_q = 32'hFFFF_FFFE;
    #1;
    release dut.retired_q;
    tick(); tick();
    chk("t6_ret_max", a_ret, 32'hFFFF_FFFF);
    tick(); tick();
    chk("t6_ret_wrap", a_ret, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
